// File: rtl/i2c_reg_reader.sv
// Burst register reader: sets the device register pointer, then reads NREG bytes and publishes
// them atomically. Defining I2C_REG_READER_AUTOPOLL_EN adds periodic bursts every POLL_DIV idle cycles.
module i2c_reg_reader #(
   parameter logic [6:0] DEV_ADDR  = 7'h68,
   parameter logic [7:0] START_REG = 8'h00,
   parameter int         NREG      = 7,
   parameter int         TO_CYC    = 100000,
   parameter int         POLL_DIV  = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [7:0]        i2c_data,
   output logic [2:0]        i2c_en,
   input  logic [2:0]        i2c_st,
   input  logic [7:0]        i2c_rd,
   output logic [NREG*8-1:0] regs,
   output logic              valid,
   output logic              busy,
   output logic              err,
   output logic [2:0]        dbg_state
);
   typedef enum logic [2:0] {S_IDLE, S_AW, S_RA, S_STP1, S_AR, S_RD, S_STP2, S_PUB} state_t;

   localparam logic [2:0] EN_IDLE = 3'd0, EN_WR = 3'd1, EN_RDACK = 3'd2, EN_RDNACK = 3'd3, EN_STOP = 3'd4;
   localparam logic [2:0] ST_WR = 3'd1, ST_ACK = 3'd2, ST_NACK = 3'd3, ST_RDV = 3'd4, ST_STOP = 3'd5;
   localparam int KW = $clog2(NREG + 1);
   localparam int TW = $clog2(TO_CYC + 1);
   localparam logic [KW-1:0] K_LAST  = KW'(NREG - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

   if (NREG < 1 || NREG > 16 || TO_CYC < 2 || POLL_DIV < 1) begin : g_bad_param
      $error("i2c_reg_reader: parameter out of range");
   end

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [TW-1:0]     to_q, to_d;
   logic [NREG*8-1:0] shadow_q, shadow_d, regs_q, regs_d;
   logic [2:0]        st_prev_q, en_q, en_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d, err_q, err_d, busy_q, busy_d, bypass_q, bypass_d;
   logic              go, st_new, ev_ack, ev_nack, ev_rdv, ev_stop, st_activity, timeout;

`ifdef I2C_REG_READER_AUTOPOLL_EN
   localparam int PW = $clog2(POLL_DIV + 1);
   logic [PW-1:0] poll_q, poll_d;
   logic          poll_hit;

   always_comb begin
      poll_hit = (state_q == S_IDLE) && (poll_q == PW'(POLL_DIV - 1));
      go       = (state_q == S_IDLE) && (start || poll_hit);
      poll_d   = (state_q != S_IDLE || go) ? '0 : poll_q + 1'b1;
   end

   always_ff @(negedge clk) begin
      if (rst) poll_q <= '0;
      else     poll_q <= poll_d;
   end
`else
   always_comb go = start;
`endif

   // A status is an event only on the cycle it changes, so a held value is consumed once.
   always_comb begin
      st_new      = (i2c_st != st_prev_q);
      ev_ack      = st_new && (i2c_st == ST_ACK);
      ev_nack     = st_new && (i2c_st == ST_NACK);
      ev_rdv      = st_new && (i2c_st == ST_RDV);
      ev_stop     = st_new && (i2c_st == ST_STOP);
      st_activity = (i2c_st == ST_WR) || (i2c_st == ST_ACK) || (i2c_st == ST_RDV) || (i2c_st == ST_STOP);
      timeout     = (state_q != S_IDLE) && (to_q == TO_LAST);

      state_d  = state_q;
      k_d      = k_q;
      shadow_d = shadow_q;
      regs_d   = regs_q;
      bypass_d = bypass_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: if (go) begin
            state_d  = S_AW;
            k_d      = '0;
            shadow_d = '0;
            bypass_d = 1'b0;
         end
         S_AW, S_RA, S_AR: begin
            if (ev_ack) begin
               state_d = (state_q == S_AW) ? S_RA : (state_q == S_RA) ? S_STP1 : S_RD;
               k_d     = '0;
            end else if (ev_nack) begin
               state_d  = S_STP2;
               err_d    = 1'b1;
               shadow_d = '0;
               bypass_d = 1'b1;
            end
         end
         S_STP1: if (ev_stop) state_d = S_AR;
         S_RD: if (ev_rdv) begin
            for (int i = 0; i < NREG; i++)
               if (k_q == KW'(i)) shadow_d[8*i +: 8] = i2c_rd;
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) state_d = S_STP2;
         end
         S_STP2: if (ev_stop) begin
            if (bypass_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_PUB;
               regs_d  = shadow_q;
               valid_d = 1'b1;
            end
         end
         S_PUB:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Timeout abandons the transfer outright; the engine gets a single STOP and no wait.
      if (timeout) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         regs_d  = regs_q;
         valid_d = 1'b0;
      end

      to_d = (state_q == S_IDLE || state_d != state_q || st_activity) ? '0 : to_q + 1'b1;

      en_d   = EN_IDLE;
      data_d = '0;
      case (state_d)
         S_AW:           begin en_d = EN_WR; data_d = {DEV_ADDR, 1'b0}; end
         S_RA:           begin en_d = EN_WR; data_d = START_REG; end
         S_AR:           begin en_d = EN_WR; data_d = {DEV_ADDR, 1'b1}; end
         S_STP1, S_STP2: en_d = EN_STOP;
         S_RD:           en_d = (k_d == K_LAST) ? EN_RDNACK : EN_RDACK;
         default:        en_d = EN_IDLE;
      endcase
      if (timeout) en_d = EN_STOP;

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         to_q      <= '0;
         shadow_q  <= '0;
         regs_q    <= '0;
         st_prev_q <= '0;
         en_q      <= EN_IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         bypass_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         to_q      <= to_d;
         shadow_q  <= shadow_d;
         regs_q    <= regs_d;
         st_prev_q <= i2c_st;
         en_q      <= en_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         bypass_q  <= bypass_d;
      end
   end

   assign i2c_data  = data_q;
   assign i2c_en    = en_q;
   assign regs      = regs_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_i2c_reg_reader.sv
// Directed bench for i2c_reg_reader: a reactive byte-engine model answers each command once,
// and a command scoreboard plus register/pulse checks cover burst, NACK, timeout and reset cases.
module tb_i2c_reg_reader;
   localparam int NREG = 7;
   localparam logic [2:0] EN_IDLE = 3'd0, EN_WR = 3'd1, EN_RDACK = 3'd2, EN_RDNACK = 3'd3, EN_STOP = 3'd4;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_ACK = 3'd2, ST_NACK = 3'd3, ST_RDV = 3'd4, ST_STOP = 3'd5;

   logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [2:0]        i2c_st = ST_IDLE;
   logic [7:0]        i2c_rd = 8'h00;
   logic [7:0]        i2c_data;
   logic [2:0]        i2c_en, dbg_state;
   logic [NREG*8-1:0] regs;
   logic              valid, busy, err;

   i2c_reg_reader #(.DEV_ADDR(7'h68), .START_REG(8'h00), .NREG(NREG), .TO_CYC(50), .POLL_DIV(200)) dut (
      .clk(clk), .rst(rst), .start(start), .i2c_data(i2c_data), .i2c_en(i2c_en), .i2c_st(i2c_st),
      .i2c_rd(i2c_rd), .regs(regs), .valid(valid), .busy(busy), .err(err), .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   int          n_vec = 0, n_err = 0, cyc = 0;
   int          valid_cnt = 0, err_cnt = 0, err_cyc = 0, last_ev_cyc = 0, nreads = 0, stall_at = -1;
   logic        stall = 1'b0, nack_en = 1'b0;
   logic [7:0]  rd_base = 8'h00, nack_byte = 8'h00;
   logic [2:0]  en_at_err = EN_IDLE;
   logic [10:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs at posedge (DUT moves on negedge), then act as the byte engine.
   task automatic tick();
      logic [10:0] exp;
      @(posedge clk);
      cyc++;
      if (valid === 1'b1) valid_cnt++;
      if (err === 1'b1) begin
         err_cnt++;
         err_cyc   = cyc;
         en_at_err = i2c_en;
      end
      if (i2c_st != ST_IDLE) begin
         i2c_st = ST_IDLE;
      end else if (!stall && i2c_en != EN_IDLE) begin
         exp = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
         check("cmd", {i2c_en, i2c_data}, exp);
         case (i2c_en)
            EN_WR: i2c_st = (nack_en && i2c_data == nack_byte) ? ST_NACK : ST_ACK;
            EN_RDACK, EN_RDNACK: begin
               i2c_rd      = rd_base + 8'(nreads);
               nreads++;
               i2c_st      = ST_RDV;
               last_ev_cyc = cyc;
               if (nreads == stall_at) stall = 1'b1;
            end
            EN_STOP: i2c_st = ST_STOP;
            default: i2c_st = ST_IDLE;
         endcase
      end
   endtask

   task automatic begin_burst(input logic [7:0] base);
      rd_base   = base;
      nreads    = 0;
      valid_cnt = 0;
      err_cnt   = 0;
   endtask

   task automatic push_full_burst();
      exp_q.push_back({EN_WR, 8'hD0});
      exp_q.push_back({EN_WR, 8'h00});
      exp_q.push_back({EN_STOP, 8'h00});
      exp_q.push_back({EN_WR, 8'hD1});
      for (int i = 0; i < NREG - 1; i++) exp_q.push_back({EN_RDACK, 8'h00});
      exp_q.push_back({EN_RDNACK, 8'h00});
      exp_q.push_back({EN_STOP, 8'h00});
   endtask

   task automatic wait_idle(input string tag, input int restart_at);
      int n = 0;
      while (busy === 1'b1 && n < 300) begin
         n++;
         start = (n == restart_at);
         tick();
      end
      start = 1'b0;
      check({tag, "_done"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic run_burst(input string tag, input int restart_at);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(tag, restart_at);
   endtask

   initial begin
      int n;
      int fall_cyc;
      repeat (3) tick();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_valid", {63'd0, valid}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_en", {61'd0, i2c_en}, 64'd0);
      check("rst_data", {56'd0, i2c_data}, 64'd0);
      check("rst_regs", {8'd0, regs}, 64'd0);
      check("rst_state", {61'd0, dbg_state}, 64'd0);
      rst = 1'b0;
      tick();

`ifdef I2C_REG_READER_AUTOPOLL_EN
      begin_burst(8'h51);
      push_full_burst();
      n = 0;
      while (busy !== 1'b1 && n < 400) begin tick(); n++; end
      check("ap_first_start", {63'd0, busy}, 64'd1);
      wait_idle("ap1", 0);
      fall_cyc = cyc;
      check("ap1_valid", 64'(valid_cnt), 64'd1);
      check("ap1_regs", {8'd0, regs}, 64'h57565554535251);
      begin_burst(8'h61);
      push_full_burst();
      n = 0;
      while (busy !== 1'b1 && n < 400) begin tick(); n++; end
      check("ap_interval", 64'(cyc - fall_cyc), 64'd200);
      wait_idle("ap2", 0);
      check("ap2_valid", 64'(valid_cnt), 64'd1);
      check("ap2_regs", {8'd0, regs}, 64'h67666564636261);
      check("ap_cmds_left", 64'(exp_q.size()), 64'd0);
`else
      // full burst, bytes 0x11..0x17
      begin_burst(8'h11);
      push_full_burst();
      run_burst("b1", 0);
      check("b1_valid", 64'(valid_cnt), 64'd1);
      check("b1_err", 64'(err_cnt), 64'd0);
      check("b1_regs", {8'd0, regs}, 64'h17161514131211);
      check("b1_cmds_left", 64'(exp_q.size()), 64'd0);

      // start re-asserted mid-burst is ignored
      begin_burst(8'hA0);
      push_full_burst();
      run_burst("b2", 10);
      repeat (5) tick();
      check("b2_no_restart", {63'd0, busy}, 64'd0);
      check("b2_valid", 64'(valid_cnt), 64'd1);
      check("b2_regs", {8'd0, regs}, 64'hA6A5A4A3A2A1A0);
      check("b2_cmds_left", 64'(exp_q.size()), 64'd0);

      // address byte NACKed: err, STOP, regs untouched
      begin_burst(8'h33);
      nack_en   = 1'b1;
      nack_byte = 8'hD0;
      exp_q.push_back({EN_WR, 8'hD0});
      exp_q.push_back({EN_STOP, 8'h00});
      run_burst("nk", 0);
      nack_en = 1'b0;
      check("nk_err", 64'(err_cnt), 64'd1);
      check("nk_valid", 64'(valid_cnt), 64'd0);
      check("nk_regs", {8'd0, regs}, 64'hA6A5A4A3A2A1A0);
      check("nk_cmds_left", 64'(exp_q.size()), 64'd0);

      // engine stalls after three bytes: RDV sampled at the next negedge, err registered
      // 50 negedges later and seen at the posedge after that -> 51 posedges apart
      begin_burst(8'h41);
      stall_at = 3;
      exp_q.push_back({EN_WR, 8'hD0});
      exp_q.push_back({EN_WR, 8'h00});
      exp_q.push_back({EN_STOP, 8'h00});
      exp_q.push_back({EN_WR, 8'hD1});
      repeat (3) exp_q.push_back({EN_RDACK, 8'h00});
      run_burst("to", 0);
      check("to_err", 64'(err_cnt), 64'd1);
      check("to_latency", 64'(err_cyc - last_ev_cyc), 64'd51);
      check("to_stop", {61'd0, en_at_err}, {61'd0, EN_STOP});
      check("to_valid", 64'(valid_cnt), 64'd0);
      check("to_regs", {8'd0, regs}, 64'hA6A5A4A3A2A1A0);
      check("to_cmds_left", 64'(exp_q.size()), 64'd0);
      stall    = 1'b0;
      stall_at = -1;
      tick();
      check("to_en_idle", {61'd0, i2c_en}, 64'd0);

      // reset while reading, with k at 2
      begin_burst(8'h21);
      exp_q.push_back({EN_WR, 8'hD0});
      exp_q.push_back({EN_WR, 8'h00});
      exp_q.push_back({EN_STOP, 8'h00});
      exp_q.push_back({EN_WR, 8'hD1});
      repeat (2) exp_q.push_back({EN_RDACK, 8'h00});
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (nreads < 2 && n < 100) begin tick(); n++; end
      tick();
      rst = 1'b1;
      tick();
      check("mr_busy", {63'd0, busy}, 64'd0);
      check("mr_regs", {8'd0, regs}, 64'd0);
      check("mr_en", {61'd0, i2c_en}, 64'd0);
      check("mr_valid", 64'(valid_cnt), 64'd0);
      check("mr_cmds_left", 64'(exp_q.size()), 64'd0);
      rst = 1'b0;
      tick();

      begin_burst(8'h31);
      push_full_burst();
      run_burst("b3", 0);
      check("b3_valid", 64'(valid_cnt), 64'd1);
      check("b3_err", 64'(err_cnt), 64'd0);
      check("b3_regs", {8'd0, regs}, 64'h37363534333231);
      check("b3_cmds_left", 64'(exp_q.size()), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
